// File: rtl/nx_indirect_access_cntrl_mt.sv
// Multi-table indirect access controller: decodes CSR commands into a granted memory-port sequence.
// Optional feature macro NX_IA_SIM_TMO_EN enables the SIM_TMO opcode (grant masking to force a timeout).
module nx_indirect_access_cntrl_mt #(
    parameter int N_TABLES = 4,
    parameter int N_ENTRIES = 512,
    parameter int N_DATA_BITS = 96,
    parameter int N_REG_ADDR_BITS = 11,
    parameter logic [N_REG_ADDR_BITS-1:0] CMND_ADDRESS = 11'h020,
    parameter int N_TIMER_BITS = 6,
    parameter int N_INIT_INC_BITS = 4,
    parameter logic [N_DATA_BITS-1:0] RESET_DATA = '0,
    localparam int TW = (N_TABLES > 1) ? $clog2(N_TABLES) : 1,
    localparam int AW = $clog2(N_ENTRIES)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_stb,
    input  logic [N_REG_ADDR_BITS-1:0] reg_addr,
    input  logic [3:0]                 cmnd_op,
    input  logic [AW-1:0]              cmnd_addr,
    input  logic [TW-1:0]              cmnd_table_id,
    input  logic [N_TABLES*AW-1:0]     addr_limit,
    input  logic [N_DATA_BITS-1:0]     wr_dat,
    output logic [N_DATA_BITS-1:0]     rd_dat,
    output logic [2:0]                 stat_code,
    output logic [AW-1:0]              stat_addr,
    output logic [TW-1:0]              stat_table_id,
    output logic                       enable,
    output logic                       sw_cs,
    output logic                       sw_ce,
    output logic                       sw_we,
    output logic [AW-1:0]              sw_add,
    output logic [TW-1:0]              sw_table_id,
    output logic [N_DATA_BITS-1:0]     sw_wdat,
    input  logic [N_DATA_BITS-1:0]     sw_rdat,
    input  logic                       sw_match,
    input  logic [7:0]                 sw_aindex,
    input  logic                       grant,
    output logic                       yield,
    output logic                       reset
);
    localparam int IW = (N_INIT_INC_BITS > 0) ? N_INIT_INC_BITS : 1;

    localparam logic [3:0] OP_NOP = 4'h0, OP_READ = 4'h1, OP_WRITE = 4'h2, OP_ENABLE = 4'h3,
                           OP_DISABLE = 4'h4, OP_RESET = 4'h5, OP_INIT = 4'h6, OP_INIT_INC = 4'h7,
                           OP_SET_START = 4'h8, OP_COMPARE = 4'h9, OP_RESET_ALL = 4'hA, OP_ACK = 4'hF;
    localparam logic [2:0] ST_RDY = 3'd0, ST_BSY = 3'd1, ST_TMO = 3'd2, ST_OVR = 3'd3,
                           ST_NXM = 3'd4, ST_UOP = 3'd5, ST_PDN = 3'd7;

    typedef enum logic [3:0] {
        POWERDOWN, READY, ERROR, DO_WRITE, DO_READ, READ_DONE,
        DO_COMPARE, COMPARE_WAIT, COMPARE_DONE, DO_RESET, DO_INIT
    } state_t;

    state_t state, next_state;
    logic [2:0] err_r, next_err, next_stat;
    logic init_r, inc_mode, all_mode;
    logic [TW-1:0] tid_r;
    logic [AW-1:0] addr_r, sweep_addr, init_start_r, cur_limit, cmd_limit;
    logic [N_DATA_BITS-1:0] wdat_r;
    logic [N_TIMER_BITS-1:0] timer;
    logic [IW-1:0] inc_cnt;
    logic [AW-1:0] limits [N_TABLES];
    logic cmd_valid, op_bad, uses_tid, uses_addr, tid_bad, nxm, accept;
    logic busy, waiting, sweeping, timeout, sweep_last, last_table, grant_eff;

    for (genvar g = 0; g < N_TABLES; g++) begin : g_lim
        assign limits[g] = addr_limit[g*AW +: AW];
    end

    // Table ids beyond N_TABLES only exist when N_TABLES is not a power of two.
    if ((1 << TW) > N_TABLES) begin : g_tchk
        assign tid_bad = ({1'b0, cmnd_table_id} >= (TW+1)'(N_TABLES));
    end else begin : g_tnochk
        assign tid_bad = 1'b0;
    end

`ifdef NX_IA_SIM_TMO_EN
    localparam logic [3:0] OP_SIM_TMO = 4'hE;
    logic sim_tmo;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            sim_tmo <= 1'b0;
        else if (timeout)
            sim_tmo <= 1'b0;
        else if (accept && cmnd_op == OP_SIM_TMO)
            sim_tmo <= 1'b1;
    end
    assign grant_eff = grant & ~sim_tmo;
`else
    assign grant_eff = grant;
`endif

    assign cmd_valid  = wr_stb && (reg_addr == CMND_ADDRESS);
    assign cur_limit  = limits[tid_r];
    assign cmd_limit  = limits[cmnd_table_id];
    assign nxm        = uses_tid && (tid_bad || (uses_addr && (cmnd_addr > cmd_limit)));
    assign accept     = (state == READY) && cmd_valid && !op_bad && !nxm;
    assign waiting    = state inside {DO_WRITE, DO_READ, DO_COMPARE, DO_RESET, DO_INIT};
    assign busy       = waiting || (state inside {READ_DONE, COMPARE_WAIT, COMPARE_DONE});
    assign sweeping   = state inside {DO_RESET, DO_INIT};
    assign timeout    = waiting && (&timer);
    assign sweep_last = (state == DO_RESET) ? (sweep_addr == cur_limit) : (sweep_addr == addr_r);
    assign last_table = (tid_r == TW'(N_TABLES - 1));

    always_comb begin
        op_bad    = 1'b0;
        uses_tid  = 1'b0;
        uses_addr = 1'b0;
        case (cmnd_op)
            OP_NOP, OP_ENABLE, OP_DISABLE, OP_RESET_ALL, OP_ACK: ;
            OP_READ, OP_WRITE, OP_INIT, OP_SET_START: begin uses_tid = 1'b1; uses_addr = 1'b1; end
            OP_RESET, OP_COMPARE: uses_tid = 1'b1;
            OP_INIT_INC: begin
                uses_tid  = 1'b1;
                uses_addr = 1'b1;
                op_bad    = (N_INIT_INC_BITS == 0);
            end
`ifdef NX_IA_SIM_TMO_EN
            OP_SIM_TMO: ;
`endif
            default: op_bad = 1'b1;
        endcase
    end

    always_comb begin
        next_state = state;
        next_err   = err_r;
        if (state == ERROR) begin
            if (cmd_valid && cmnd_op == OP_ACK)
                next_state = init_r ? POWERDOWN : READY;
        end else if (cmd_valid && op_bad) begin
            next_state = ERROR; next_err = ST_UOP;
        end else if (cmd_valid && nxm) begin
            next_state = ERROR; next_err = ST_NXM;
        end else if (timeout) begin
            next_state = ERROR; next_err = ST_TMO;
        end else if (busy && cmd_valid) begin
            next_state = ERROR; next_err = ST_OVR;
        end else begin
            case (state)
                POWERDOWN: if (cmd_valid && cmnd_op == OP_ENABLE) next_state = READY;
                READY: if (cmd_valid) begin
                    case (cmnd_op)
                        OP_READ:                 next_state = DO_READ;
                        OP_WRITE:                next_state = DO_WRITE;
                        OP_DISABLE:              next_state = POWERDOWN;
                        OP_RESET, OP_RESET_ALL:  next_state = DO_RESET;
                        OP_INIT, OP_INIT_INC:    next_state = DO_INIT;
                        OP_COMPARE:              next_state = DO_COMPARE;
                        default: ;
                    endcase
                end
                DO_WRITE:     if (grant_eff) next_state = READY;
                DO_READ:      if (grant_eff) next_state = READ_DONE;
                READ_DONE:    next_state = READY;
                DO_COMPARE:   if (grant_eff) next_state = COMPARE_WAIT;
                COMPARE_WAIT: next_state = COMPARE_DONE;
                COMPARE_DONE: next_state = READY;
                DO_RESET:     if (grant_eff && sweep_last && (!all_mode || last_table)) next_state = READY;
                DO_INIT:      if (grant_eff && sweep_last) next_state = READY;
                default: ;
            endcase
        end
    end

    always_comb begin
        case (next_state)
            POWERDOWN: next_stat = ST_PDN;
            READY:     next_stat = ST_RDY;
            ERROR:     next_stat = next_err;
            default:   next_stat = ST_BSY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= POWERDOWN;  err_r <= ST_RDY;  stat_code <= ST_PDN;
            init_r <= 1'b1;  inc_mode <= 1'b0;  all_mode <= 1'b0;
            tid_r <= '0;  addr_r <= '0;  sweep_addr <= '0;  init_start_r <= '0;
            wdat_r <= '0;  timer <= '0;  inc_cnt <= '0;  rd_dat <= '0;
            sw_cs <= 1'b0;  sw_ce <= 1'b0;  sw_we <= 1'b0;
        end else begin
            state     <= next_state;
            err_r     <= next_err;
            stat_code <= next_stat;
            sw_cs <= next_state inside {DO_WRITE, DO_READ, DO_COMPARE, DO_RESET, DO_INIT};
            sw_we <= next_state inside {DO_WRITE, DO_RESET, DO_INIT};
            sw_ce <= (next_state == DO_COMPARE);
            timer <= (waiting && !grant_eff && next_state != ERROR) ? timer + 1'b1 : '0;

            case (state)
                POWERDOWN:    rd_dat <= wr_dat;
                READ_DONE:    rd_dat <= sw_rdat;
                COMPARE_DONE: rd_dat <= N_DATA_BITS'({sw_match, sw_aindex});
                default: ;
            endcase

            if (state == POWERDOWN && next_state == READY)
                init_r <= 1'b0;

            if (accept) begin
                case (cmnd_op)
                    OP_READ, OP_WRITE, OP_COMPARE: begin
                        tid_r <= cmnd_table_id; addr_r <= cmnd_addr; wdat_r <= wr_dat;
                    end
                    OP_RESET: begin
                        tid_r <= cmnd_table_id; sweep_addr <= '0; all_mode <= 1'b0;
                    end
                    OP_RESET_ALL: begin
                        tid_r <= '0; sweep_addr <= '0; all_mode <= 1'b1;
                    end
                    OP_INIT, OP_INIT_INC: begin
                        tid_r <= cmnd_table_id; addr_r <= cmnd_addr; wdat_r <= wr_dat;
                        sweep_addr <= init_start_r; inc_mode <= (cmnd_op == OP_INIT_INC); inc_cnt <= '0;
                    end
                    OP_SET_START: init_start_r <= cmnd_addr;
                    OP_DISABLE:   init_r <= 1'b1;
                    default: ;
                endcase
            end

            // A granted sweep step moves to the next entry, or to the next table during RESET_ALL.
            if (sweeping && grant_eff && next_state != ERROR) begin
                if (!sweep_last)
                    sweep_addr <= sweep_addr + 1'b1;
                else if (state == DO_RESET && all_mode && !last_table) begin
                    tid_r <= tid_r + 1'b1;
                    sweep_addr <= '0;
                end
                if (state == DO_INIT && inc_mode)
                    inc_cnt <= inc_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        sw_wdat = wdat_r;
        if (state == DO_RESET)
            sw_wdat = RESET_DATA;
        else if (state == DO_INIT && inc_mode && N_INIT_INC_BITS > 0)
            sw_wdat[IW-1:0] = wdat_r[IW-1:0] + inc_cnt;
    end

    assign sw_add        = sweeping ? sweep_addr : addr_r;
    assign sw_table_id   = tid_r;
    assign stat_table_id = tid_r;
    assign stat_addr     = (state == POWERDOWN) ? '0 : cur_limit;
    assign enable        = ~init_r;
    assign yield         = timer[N_TIMER_BITS-1];
    assign reset         = sweeping;
endmodule

// File: tb/tb_nx_indirect_access_cntrl_mt.sv
// Self-checking bench for nx_indirect_access_cntrl_mt: directed commands plus a memory-access scoreboard.
module tb_nx_indirect_access_cntrl_mt;
    localparam int TW = 2, AW = 9, DW = 96;
    localparam logic [10:0] CMND = 11'h020;
    localparam logic [2:0] S_RDY = 3'd0, S_BSY = 3'd1, S_TMO = 3'd2, S_OVR = 3'd3,
                           S_NXM = 3'd4, S_UOP = 3'd5, S_PDN = 3'd7;
    localparam logic [3:0] OP_READ = 4'h1, OP_WRITE = 4'h2, OP_ENABLE = 4'h3, OP_DISABLE = 4'h4,
                           OP_RESET = 4'h5, OP_INIT_INC = 4'h7, OP_SET_START = 4'h8,
                           OP_COMPARE = 4'h9, OP_RESET_ALL = 4'hA, OP_ACK = 4'hF;
    localparam logic [DW-1:0] RDATA = 96'hDEAD_BEEF_0BAD_F00D_1357_9BDF;

    logic clk = 1'b0;
    logic rst, wr_stb, enable, sw_cs, sw_ce, sw_we, sw_match, grant, yield, reset;
    logic [10:0] reg_addr;
    logic [3:0] cmnd_op;
    logic [AW-1:0] cmnd_addr, stat_addr, sw_add;
    logic [TW-1:0] cmnd_table_id, stat_table_id, sw_table_id;
    logic [4*AW-1:0] addr_limit;
    logic [DW-1:0] wr_dat, rd_dat, sw_wdat, sw_rdat;
    logic [2:0] stat_code;
    logic [7:0] sw_aindex;

    nx_indirect_access_cntrl_mt dut (
        .clk(clk), .rst(rst), .wr_stb(wr_stb), .reg_addr(reg_addr), .cmnd_op(cmnd_op),
        .cmnd_addr(cmnd_addr), .cmnd_table_id(cmnd_table_id), .addr_limit(addr_limit),
        .wr_dat(wr_dat), .rd_dat(rd_dat), .stat_code(stat_code), .stat_addr(stat_addr),
        .stat_table_id(stat_table_id), .enable(enable), .sw_cs(sw_cs), .sw_ce(sw_ce),
        .sw_we(sw_we), .sw_add(sw_add), .sw_table_id(sw_table_id), .sw_wdat(sw_wdat),
        .sw_rdat(sw_rdat), .sw_match(sw_match), .sw_aindex(sw_aindex), .grant(grant),
        .yield(yield), .reset(reset)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic we; logic ce; logic [TW-1:0] tid; logic [AW-1:0] addr; logic [DW-1:0] data; logic sweep;
    } acc_t;
    acc_t exp_q[$];
    int checks = 0, errors = 0;
    logic exp_enable;
    int limits[4] = '{2, 1, 7, 3};

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expectAccess(input logic we, input logic ce, input int tid, input int addr,
                                input logic [DW-1:0] data, input logic sweep);
        acc_t a;
        a.we = we; a.ce = ce; a.tid = TW'(tid); a.addr = AW'(addr); a.data = data; a.sweep = sweep;
        exp_q.push_back(a);
    endtask

    task automatic applyStimulus(input logic [3:0] op, input int tid, input int addr);
        @(posedge clk); #1;
        wr_stb = 1'b1; reg_addr = CMND; cmnd_op = op;
        cmnd_table_id = TW'(tid); cmnd_addr = AW'(addr);
        @(posedge clk); #1;
        wr_stb = 1'b0; reg_addr = '0;
    endtask

    task automatic waitStat(input logic [2:0] code, input int budget, output int n);
        n = 0;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (stat_code == code) begin n = i; break; end
        end
        if (n == 0) checkOutput("stat_wait", stat_code, code);
    endtask

    // Every granted memory access must match the oldest access the model predicted.
    always @(negedge clk) begin
        if (!rst) begin
            checkOutput("enable", enable, exp_enable);
            if (sw_cs && grant) begin
                checkOutput("access_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    acc_t a;
                    a = exp_q.pop_front();
                    checkOutput("acc_we", sw_we, a.we);
                    checkOutput("acc_ce", sw_ce, a.ce);
                    checkOutput("acc_tid", sw_table_id, a.tid);
                    checkOutput("acc_addr", sw_add, a.addr);
                    checkOutput("acc_reset", reset, a.sweep);
                    if (a.we || a.ce) checkOutput("acc_wdat", sw_wdat, a.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n, total, tmo_at;
        logic [DW-1:0] base, d;
        logic [15:0] nibs;
        rst = 1'b1; wr_stb = 1'b0; reg_addr = '0; cmnd_op = '0; cmnd_addr = '0; cmnd_table_id = '0;
        wr_dat = '0; sw_rdat = RDATA; sw_match = 1'b0; sw_aindex = '0; grant = 1'b0; exp_enable = 1'b0;
        for (int i = 0; i < 4; i++) addr_limit[i*AW +: AW] = AW'(limits[i]);

        repeat (2) @(negedge clk);
        checkOutput("rst_stat", stat_code, S_PDN);
        checkOutput("rst_rd_dat", rd_dat, 0);
        checkOutput("rst_sw_cs", {sw_cs, sw_we, sw_ce}, 0);
        checkOutput("rst_yield", yield, 0);
        checkOutput("rst_enable", enable, 0);
        rst = 1'b0;
        wr_dat = 96'h1234;
        @(negedge clk);
        checkOutput("pd_rd_follow", rd_dat, 96'h1234);
        checkOutput("pd_stat_addr", stat_addr, 0);

        applyStimulus(OP_ENABLE, 0, 0);
        exp_enable = 1'b1;
        @(negedge clk);
        checkOutput("enable_stat", stat_code, S_RDY);
        checkOutput("enable_stat_addr", stat_addr, 2);

        grant = 1'b1;
        wr_dat = 96'hA5A5_0000_1111_2222_3333_4444;
        expectAccess(1, 0, 2, 5, wr_dat, 0);
        applyStimulus(OP_WRITE, 2, 5);
        waitStat(S_RDY, 10, n);
        checkOutput("write_busy_cycles", n - 1, 1);
        checkOutput("write_stat_tid", stat_table_id, 2);

        expectAccess(0, 0, 2, 5, '0, 0);
        applyStimulus(OP_READ, 2, 5);
        waitStat(S_RDY, 10, n);
        checkOutput("read_busy_cycles", n - 1, 2);
        checkOutput("read_rd_dat", rd_dat, RDATA);

        sw_match = 1'b1; sw_aindex = 8'h5A;
        wr_dat = 96'h77;
        expectAccess(0, 1, 1, 0, wr_dat, 0);
        applyStimulus(OP_COMPARE, 1, 0);
        waitStat(S_RDY, 10, n);
        checkOutput("compare_rd_dat", rd_dat, 96'h15A);

        total = 0;
        for (int t = 0; t < 4; t++)
            for (int a = 0; a <= limits[t]; a++) begin
                expectAccess(1, 0, t, a, '0, 1);
                total++;
            end
        checkOutput("reset_all_model_count", total, 17);
        applyStimulus(OP_RESET_ALL, 0, 0);
        waitStat(S_RDY, 60, n);
        checkOutput("reset_all_cycles", n - 1, total);
        checkOutput("reset_all_last_tid", stat_table_id, 3);
        checkOutput("reset_all_drained", exp_q.size(), 0);

        applyStimulus(OP_SET_START, 2, 2);
        base = 96'h0123_4567_89AB_CDEF_0000_000E;
        wr_dat = base;
        for (int k = 0; k <= 3; k++) begin
            d = base;
            d[3:0] = base[3:0] + 4'(k);
            nibs[15-4*k -: 4] = d[3:0];
            expectAccess(1, 0, 2, 2 + k, d, 1);
        end
        checkOutput("init_inc_model_nibbles", nibs, 16'hEF01);
        applyStimulus(OP_INIT_INC, 2, 5);
        waitStat(S_RDY, 30, n);
        checkOutput("init_inc_cycles", n - 1, 4);
        checkOutput("init_inc_drained", exp_q.size(), 0);

        grant = 1'b0;
        applyStimulus(OP_READ, 0, 1);
        tmo_at = 0;
        for (int k = 1; k <= 80; k++) begin
            @(negedge clk);
            if (stat_code == S_TMO) begin tmo_at = k; break; end
            checkOutput("tmo_yield", yield, (k - 1) >= 32);
        end
        checkOutput("tmo_cycle", tmo_at, (1 << 6) + 1);
        checkOutput("tmo_yield_clear", yield, 0);
        grant = 1'b1;
        applyStimulus(OP_ACK, 0, 0);
        waitStat(S_RDY, 5, n);

        applyStimulus(OP_WRITE, 0, 9);
        @(negedge clk);
        checkOutput("nxm_stat", stat_code, S_NXM);
        applyStimulus(OP_ACK, 0, 0);
        waitStat(S_RDY, 5, n);

        applyStimulus(4'hB, 0, 9);
        @(negedge clk);
        checkOutput("uop_stat", stat_code, S_UOP);
        applyStimulus(OP_ACK, 0, 0);
        waitStat(S_RDY, 5, n);
`ifndef NX_IA_SIM_TMO_EN
        applyStimulus(4'hE, 0, 0);
        @(negedge clk);
        checkOutput("sim_tmo_uop_stat", stat_code, S_UOP);
        applyStimulus(OP_ACK, 0, 0);
        waitStat(S_RDY, 5, n);
`endif

        grant = 1'b0;
        applyStimulus(OP_RESET, 1, 0);
        repeat (3) @(negedge clk);
        checkOutput("ovr_pre_reset_out", reset, 1);
        applyStimulus(OP_WRITE, 1, 0);
        @(negedge clk);
        checkOutput("ovr_stat", stat_code, S_OVR);
        checkOutput("ovr_sw_cs", sw_cs, 0);
        grant = 1'b1;
        applyStimulus(OP_ACK, 0, 0);
        waitStat(S_RDY, 5, n);

        applyStimulus(OP_DISABLE, 0, 0);
        exp_enable = 1'b0;
        waitStat(S_PDN, 5, n);
        checkOutput("disable_cycles", n, 1);
        checkOutput("disable_stat_addr", stat_addr, 0);

        applyStimulus(OP_ENABLE, 0, 0);
        exp_enable = 1'b1;
        for (int a = 0; a < 3; a++) expectAccess(1, 0, 2, a, '0, 1);
        applyStimulus(OP_RESET, 2, 0);
        repeat (3) @(negedge clk);
        #1 rst = 1'b1;
        exp_enable = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checkOutput("midrst_sw_cs", sw_cs, 0);
        end
        checkOutput("midrst_stat", stat_code, S_PDN);
        checkOutput("midrst_reset_out", reset, 0);
        checkOutput("midrst_drained", exp_q.size(), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("post_rst_stat", stat_code, S_PDN);
        checkOutput("post_rst_sw_cs", sw_cs, 0);

        checkOutput("final_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
